fetch_entry_queue: RTL and testbench

- Elastic buffer between the frontend fetch output and the decode/issue-register stage.
- Stores fetch entries of type ariane_pkg::fetch_entry_t (address, instruction, branch_predict, ex) and presents them in order on a valid/ready handshake.
- Decouples frontend stalls from decode back-pressure.
- Discards all contents on a controller flush, and stops accepting entries after an excepting entry until that entry has drained.

---
 rtl/fetch_entry_queue.sv | 171 +++++++++++++++++
 tb/tb_fetch_entry_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: elastic FIFO between the frontend and decode.
// It holds fetch entries in order on a valid/ready handshake, drops its
// contents on a flush, and blocks input behind an excepting entry.

package config_pkg;
    typedef struct packed {
        logic [31:0] XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

package ariane_pkg;
    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        cf_t         cf;
        logic [63:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;
endpackage

module fetch_entry_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH        = 4,
    parameter bit                    FALL_THROUGH = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  ariane_pkg::fetch_entry_t     fetch_entry_i,
    input  logic                         fetch_entry_valid_i,
    output logic                         fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t     fetch_entry_o,
    output logic                         fetch_entry_valid_o,
    input  logic                         fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]       usage_o,
    output logic                         ex_hold_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Elaboration-time sanity checks on the configuration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_entry_queue: DEPTH must be a power of two >= 2");
    end
    if (CVA6Cfg.XLEN > 32'd64) begin : g_bad_xlen
        $error("fetch_entry_queue: unsupported XLEN");
    end

    ariane_pkg::fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ex_hold_q, ex_hold_d;

    logic empty, full, ft_active;
    logic push, pop, write_en, pop_st;

    // Handshake decode: ready/valid, fall-through bypass and the push/pop split.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        ft_active = FALL_THROUGH && empty;

        // A flush swallows the input, so ready stays high and nothing is stored.
        fetch_entry_ready_o = flush_i || (!ex_hold_q && (!full || fetch_entry_ready_i));

        if (ft_active) begin
            fetch_entry_valid_o = fetch_entry_valid_i && !ex_hold_q && !flush_i;
            fetch_entry_o       = fetch_entry_i;
        end else begin
            fetch_entry_valid_o = !empty && !flush_i;
            fetch_entry_o       = mem_q[rd_ptr_q];
        end

        push     = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
        pop      = fetch_entry_valid_o && fetch_entry_ready_i;
        // A bypassed entry consumed in the same cycle never touches storage.
        write_en = push && !(ft_active && pop);
        pop_st   = pop && !ft_active;
    end

    // Next-state for pointers, occupancy and the exception hold flag.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ex_hold_d = ex_hold_q;

        if (flush_i) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            ex_hold_d = 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_st) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(write_en) - CW'(pop_st);

            // Only one excepting entry can be in flight, so any excepting pop clears.
            if (write_en && fetch_entry_i.ex.valid) begin
                ex_hold_d = 1'b1;
            end else if (pop_st && fetch_entry_o.ex.valid) begin
                ex_hold_d = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ex_hold_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ex_hold_q <= ex_hold_d;
        end
    end

    // Entry storage; a flush leaves the data in place and only rewinds the pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en && !flush_i) begin
            mem_q[wr_ptr_q] <= fetch_entry_i;
        end
    end

    assign usage_o   = count_q;
    assign ex_hold_o = ex_hold_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (full && write_en && !flush_i) |-> pop_st);

    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        empty |-> !pop_st);

    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fetch_entry_valid_o && !fetch_entry_ready_i && !flush_i) |=> $stable(fetch_entry_o));

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed testbench for fetch_entry_queue: a registered-output instance and
// a fall-through instance, each exercised by per-scenario tasks.

module tb_fetch_entry_queue;
    import ariane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Registered-output instance (FALL_THROUGH = 0).
    logic         rst_n;
    logic         flush;
    fetch_entry_t ent_i, ent_o;
    logic         vld_i, rdy_o, vld_o, rdy_i, exh;
    logic [2:0]   usage;

    // Fall-through instance.
    logic         flush2;
    fetch_entry_t ent_i2, ent_o2;
    logic         vld_i2, rdy_o2, vld_o2, rdy_i2, exh2;
    logic [2:0]   usage2;

    fetch_entry_queue #(.DEPTH(4), .FALL_THROUGH(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fetch_entry_i(ent_i), .fetch_entry_valid_i(vld_i), .fetch_entry_ready_o(rdy_o),
        .fetch_entry_o(ent_o), .fetch_entry_valid_o(vld_o), .fetch_entry_ready_i(rdy_i),
        .usage_o(usage), .ex_hold_o(exh)
    );

    fetch_entry_queue #(.DEPTH(4), .FALL_THROUGH(1'b1)) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2),
        .fetch_entry_i(ent_i2), .fetch_entry_valid_i(vld_i2), .fetch_entry_ready_o(rdy_o2),
        .fetch_entry_o(ent_o2), .fetch_entry_valid_o(vld_o2), .fetch_entry_ready_i(rdy_i2),
        .usage_o(usage2), .ex_hold_o(exh2)
    );

    function automatic fetch_entry_t mk(input logic [63:0] a, input logic exv);
        fetch_entry_t e;
        e             = '0;
        e.address     = a;
        e.instruction = a[31:0] ^ 32'h0000_0013;
        e.ex.valid    = exv;
        e.ex.cause    = exv ? 64'd1 : 64'd0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_o); end
        checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy_o); end
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL reset_usage: got %0d expected 0", usage); end
        checks++; if (exh !== 1'b0) begin errors++; $display("FAIL reset_ex_hold: got %b expected 0", exh); end
        checks++; if (ent_o !== fetch_entry_t'('0)) begin errors++; $display("FAIL reset_entry: got %h expected 0", ent_o); end
    endtask

    task automatic test_basic_order();
        rdy_i = 1'b0;
        vld_i = 1'b1; ent_i = mk(64'h8000_0000, 1'b0); tick();
        ent_i = mk(64'h8000_0004, 1'b0); tick();
        ent_i = mk(64'h8000_0008, 1'b0); tick();
        vld_i = 1'b0; #1;
        checks++; if (usage !== 3'd3) begin errors++; $display("FAIL basic_usage: got %0d expected 3", usage); end
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", vld_o); end
        checks++; if (ent_o.address !== 64'h8000_0000) begin errors++; $display("FAIL basic_head: got %h expected 80000000", ent_o.address); end
        rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ent_o.address !== 64'h8000_0000 + 64'(4 * k) || vld_o !== 1'b1) begin
                errors++;
                $display("FAIL basic_pop%0d: got %h/%b expected %h/1", k, ent_o.address, vld_o, 64'h8000_0000 + 64'(4 * k));
            end
            tick();
        end
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", vld_o); end
        rdy_i = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [63:0] exp_a;
        rdy_i = 1'b0; vld_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ent_i = mk(64'h100 + 64'(4 * k), 1'b0); tick();
        end
        #1;
        checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", rdy_o); end
        checks++; if (usage !== 3'd4) begin errors++; $display("FAIL full_usage: got %0d expected 4", usage); end
        rdy_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ent_i = mk(64'h200 + 64'(4 * k), 1'b0);
            exp_a = (k < 4) ? 64'h100 + 64'(4 * k) : 64'h200 + 64'(4 * (k - 4));
            #1;
            checks++;
            if (ent_o.address !== exp_a || rdy_o !== 1'b1) begin
                errors++;
                $display("FAIL wrap_stream%0d: got %h/%b expected %h/1", k, ent_o.address, rdy_o, exp_a);
            end
            tick();
        end
        vld_i = 1'b0; rdy_i = 1'b0; #1;
        checks++; if (usage !== 3'd4) begin errors++; $display("FAIL wrap_usage: got %0d expected 4", usage); end
        rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ent_o.address !== 64'h210 + 64'(4 * k)) begin
                errors++;
                $display("FAIL wrap_drain%0d: got %h expected %h", k, ent_o.address, 64'h210 + 64'(4 * k));
            end
            tick();
        end
        rdy_i = 1'b0;
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d expected 0", usage); end
    endtask

    task automatic test_exception_hold();
        rdy_i = 1'b0;
        vld_i = 1'b1; ent_i = mk(64'h300, 1'b1); tick();
        ent_i = mk(64'h304, 1'b0); #1;
        checks++; if (exh !== 1'b1) begin errors++; $display("FAIL ex_hold_set: got %b expected 1", exh); end
        checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL ex_ready_low: got %b expected 0", rdy_o); end
        tick();
        checks++; if (usage !== 3'd1) begin errors++; $display("FAIL ex_blocked_usage: got %0d expected 1", usage); end
        rdy_i = 1'b1; #1;
        checks++; if (ent_o.address !== 64'h300 || ent_o.ex.valid !== 1'b1) begin errors++; $display("FAIL ex_head: got %h/%b expected 300/1", ent_o.address, ent_o.ex.valid); end
        tick();
        vld_i = 1'b0;
        checks++; if (exh !== 1'b0) begin errors++; $display("FAIL ex_hold_clear: got %b expected 0", exh); end
        checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL ex_ready_back: got %b expected 1", rdy_o); end
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL ex_usage_after: got %0d expected 0", usage); end
        rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        rdy_i = 1'b0; vld_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ent_i = mk(64'h400 + 64'(4 * k), 1'b0); tick();
        end
        flush = 1'b1; ent_i = mk(64'h4FC, 1'b0); rdy_i = 1'b1; #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", vld_o); end
        tick();
        flush = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; #1;
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL flush_usage: got %0d expected 0", usage); end
        checks++; if (exh !== 1'b0) begin errors++; $display("FAIL flush_ex_hold: got %b expected 0", exh); end
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL flush_after_valid: got %b expected 0", vld_o); end
        vld_i = 1'b1; ent_i = mk(64'h500, 1'b0); tick();
        vld_i = 1'b0; #1;
        checks++; if (ent_o.address !== 64'h500 || usage !== 3'd1) begin errors++; $display("FAIL flush_next_entry: got %h/%0d expected 500/1", ent_o.address, usage); end
        rdy_i = 1'b1; tick(); rdy_i = 1'b0;
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL flush_drain: got %0d expected 0", usage); end
    endtask

    task automatic test_fall_through();
        vld_i2 = 1'b1; ent_i2 = mk(64'h1000, 1'b0); rdy_i2 = 1'b1; #1;
        checks++; if (vld_o2 !== 1'b1 || ent_o2.address !== 64'h1000) begin errors++; $display("FAIL ft_bypass: got %b/%h expected 1/1000", vld_o2, ent_o2.address); end
        tick();
        checks++; if (usage2 !== 3'd0) begin errors++; $display("FAIL ft_usage_zero: got %0d expected 0", usage2); end
        rdy_i2 = 1'b0; ent_i2 = mk(64'h2000, 1'b0); #1;
        checks++; if (vld_o2 !== 1'b1 || ent_o2.address !== 64'h2000) begin errors++; $display("FAIL ft_bypass_stall: got %b/%h expected 1/2000", vld_o2, ent_o2.address); end
        tick();
        vld_i2 = 1'b0; #1;
        checks++; if (usage2 !== 3'd1) begin errors++; $display("FAIL ft_usage_one: got %0d expected 1", usage2); end
        checks++; if (vld_o2 !== 1'b1 || ent_o2.address !== 64'h2000) begin errors++; $display("FAIL ft_stored: got %b/%h expected 1/2000", vld_o2, ent_o2.address); end
        rdy_i2 = 1'b1; tick(); rdy_i2 = 1'b0;
        checks++; if (usage2 !== 3'd0) begin errors++; $display("FAIL ft_drain: got %0d expected 0", usage2); end
    endtask

    task automatic test_async_reset();
        rdy_i = 1'b0;
        vld_i = 1'b1; ent_i = mk(64'h600, 1'b0); tick();
        ent_i = mk(64'h604, 1'b1); tick();
        vld_i = 1'b0; #1;
        checks++; if (usage !== 3'd2 || exh !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got %0d/%b expected 2/1", usage, exh); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", vld_o); end
        checks++; if (usage !== 3'd0) begin errors++; $display("FAIL arst_usage: got %0d expected 0", usage); end
        checks++; if (exh !== 1'b0) begin errors++; $display("FAIL arst_ex_hold: got %b expected 0", exh); end
        checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", rdy_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; ent_i = '0;
        flush2 = 1'b0; vld_i2 = 1'b0; rdy_i2 = 1'b0; ent_i2 = '0;
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_order();
        test_full_wrap();
        test_exception_hold();
        test_flush();
        test_fall_through();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
